// File: rtl/vga_tile_reader.sv
// 640x480@60 VGA scan-out of a 40x30 tile VRAM: timing counters, tile address generation,
// and a two-stage pipeline that keeps sync/DE aligned with colour. Optional macro: TILE_GRID_EN.
module vga_tile_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int X_TILES    = 40,
    parameter int Y_TILES    = 30,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vram_ready,
    input  logic [DATA_WIDTH-1:0] vram_data,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [4:0] Y_TILES_C = 5'(Y_TILES);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Stage 0. VRAM read port: read_en/read_addr are combinational from the counters; the
    // matching byte appears on vram_data exactly one clk later. There is no back-pressure.
    logic                  frame_origin;
    logic                  ok_now;
    logic                  vis;
    logic [5:0]            tile_x;
    logic [4:0]            tile_y;
    logic [ADDR_WIDTH-1:0] tile_addr;
    logic                  hs_raw;
    logic                  vs_raw;
    logic                  grid_raw;

    always_comb begin
        frame_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);
        // The origin pixel itself already uses the freshly sampled ready flag.
        ok_now       = frame_origin ? vram_ready : frame_ok;
        tile_x       = h_cnt[9:4];
        tile_y       = v_cnt[8:4];
        vis          = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C) && (tile_y < Y_TILES_C);
        tile_addr    = ADDR_WIDTH'(tile_y) * ADDR_WIDTH'(X_TILES) + ADDR_WIDTH'(tile_x);
        read_addr    = vis ? tile_addr : '0;
        read_en      = vis && ok_now && !rst;
        hs_raw       = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_raw       = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        grid_raw     = vis && ((h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok <= 1'b0;
        end else if (frame_origin) begin
            frame_ok <= vram_ready;
        end
    end

    // Stage 1: control travels alongside the outstanding VRAM read.
    logic vis_d1;
    logic ok_d1;
    logic hs_d1;
    logic vs_d1;
    logic first_d1;
    logic grid_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vis_d1   <= 1'b0;
            ok_d1    <= 1'b0;
            hs_d1    <= 1'b1;
            vs_d1    <= 1'b1;
            first_d1 <= 1'b0;
            grid_d1  <= 1'b0;
        end else begin
            vis_d1   <= vis;
            ok_d1    <= ok_now;
            hs_d1    <= hs_raw;
            vs_d1    <= vs_raw;
            first_d1 <= frame_origin;
            grid_d1  <= grid_raw;
        end
    end

    // Stage 2: RRRGGGBB expanded to 4:4:4 by replicating the top bits.
    logic [3:0] r_exp;
    logic [3:0] g_exp;
    logic [3:0] b_exp;
    logic       show_vram;
    logic       show_grid;

    always_comb begin
        r_exp     = {vram_data[7:5], vram_data[7]};
        g_exp     = {vram_data[4:2], vram_data[4]};
        b_exp     = {vram_data[1:0], vram_data[1:0]};
        show_vram = vis_d1 && ok_d1;
`ifdef TILE_GRID_EN
        show_grid = vis_d1 && grid_d1;
`else
        show_grid = 1'b0 & grid_d1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            vga_r       <= 4'd0;
            vga_g       <= 4'd0;
            vga_b       <= 4'd0;
        end else begin
            de          <= vis_d1;
            hsync       <= hs_d1;
            vsync       <= vs_d1;
            frame_start <= first_d1;
            if (show_grid) begin
                vga_r <= 4'hF;
                vga_g <= 4'hF;
                vga_b <= 4'hF;
            end else if (show_vram) begin
                vga_r <= r_exp;
                vga_g <= g_exp;
                vga_b <= b_exp;
            end else begin
                vga_r <= 4'd0;
                vga_g <= 4'd0;
                vga_b <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_reader.sv
// Randomized bench for vga_tile_reader: a pixel-position model predicts every output each clk.
module tb_vga_tile_reader;

    logic        clk;
    logic        rst;
    logic        vram_ready;
    logic [7:0]  vram_data;
    logic        read_en;
    logic [10:0] read_addr;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;

    vga_tile_reader dut (
        .clk         (clk),
        .rst         (rst),
        .vram_ready  (vram_ready),
        .vram_data   (vram_data),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM responder: registered read, garbage when not enabled
    logic [7:0] mem [0:1199];
    always @(posedge clk) begin
        if (read_en) vram_data <= mem[read_addr];
        else         vram_data <= 8'($urandom);
    end

    // scoreboard: expected {de, hsync, vsync, frame_start, r, g, b}
    localparam logic [15:0] RESET_ENTRY = 16'h6000;
    logic [15:0] exp_q[$];
    int total;
    int bad;
    int ph;
    int pv;
    bit m_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s h=%0d v=%0d got=%0h want=%0h", tag, ph, pv, got, want);
        end
    endtask

    function automatic logic [15:0] model(input int h, input int v, input bit ok);
        bit vis;
        int px;
        int r;
        int g;
        int b;
        vis = (h < 640) && (v < 480);
        r = 0;
        g = 0;
        b = 0;
        if (vis && ok) begin
            px = mem[(v / 16) * 40 + h / 16];
            r = (px / 32) * 2 + (px / 32) / 4;
            g = ((px / 4) % 8) * 2 + ((px / 4) % 8) / 4;
            b = (px % 4) * 5;
        end
`ifdef TILE_GRID_EN
        if (vis && ((h % 16 == 0) || (v % 16 == 0))) begin
            r = 15;
            g = 15;
            b = 15;
        end
`endif
        return {vis, !((h >= 656) && (h < 752)), !((v >= 490) && (v < 492)),
                (h == 0) && (v == 0), 4'(r), 4'(g), 4'(b)};
    endfunction

    // driver tasks
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            vram_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_read_en", read_en, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        ph = 0;
        pv = 0;
        exp_q.delete();
        exp_q.push_back(RESET_ENTRY);
        exp_q.push_back(RESET_ENTRY);
    endtask

    task automatic run_cycles(input int n, input bit ready_at_origin);
        logic [15:0] e;
        bit vis;
        for (int i = 0; i < n; i++) begin
            if (ph == 0 && pv == 0) begin
                vram_ready = ready_at_origin;
                m_ok = ready_at_origin;
            end else begin
                vram_ready = 1'($urandom_range(0, 1));
            end
            vis = (ph < 640) && (pv < 480);
            exp_q.push_back(model(ph, pv, m_ok));
            @(negedge clk);
            check("read_en", read_en, vis && m_ok);
            check("read_addr", read_addr, vis ? (pv / 16) * 40 + ph / 16 : 0);
            e = exp_q.pop_front();
            check("de", de, e[15]);
            check("hsync", hsync, e[14]);
            check("vsync", vsync, e[13]);
            check("frame_start", frame_start, e[12]);
            check("rgb", {vga_r, vga_g, vga_b}, e[11:0]);
            @(posedge clk);
            #1;
            ph++;
            if (ph == 800) begin
                ph = 0;
                pv = (pv + 1) % 525;
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_ok = 1'b0;
        ph = 0;
        pv = 0;
        rst = 1'b1;
        vram_ready = 1'b0;
        for (int i = 0; i < 1200; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0;
        mem[81] = 8'h1F;

        // blank frame: sync timing only, ready changes mid-frame are ignored
        do_reset(5);
        run_cycles(1700, 1'b0);
        // displayed frame: origin pixel, tile rows 0..2 including (17,33)
        do_reset(1);
        run_cycles(28000, 1'b1);
        // blank frame, then a 1-clk reset at h=300, v=2
        do_reset(2);
        run_cycles(1900, 1'b0);
        do_reset(1);
        run_cycles(4000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
